// File: rtl/easy_axi_rd_slv.sv
// easy_axi_rd_slv: single-outstanding AXI read slave whose read data is the beat byte address.
// Requests outside the decoded window, or with an unsupported size/burst, return SLVERR beats.

`ifndef AXI_ID_W
   `define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
   `define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
   `define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
   `define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
   `define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
   `define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
   `define AXI_RESP_W 2
`endif

module easy_axi_rd_slv #(
   parameter logic [`AXI_ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned            MEM_BYTES = 4096,
   parameter int unsigned            RD_LAT    = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // read-address channel
   input  logic                    axi_slv_arvalid,
   output logic                    axi_slv_arready,
   input  logic [`AXI_ID_W-1:0]    axi_slv_arid,
   input  logic [`AXI_ADDR_W-1:0]  axi_slv_araddr,
   input  logic [`AXI_LEN_W-1:0]   axi_slv_arlen,
   input  logic [`AXI_SIZE_W-1:0]  axi_slv_arsize,
   input  logic [`AXI_BURST_W-1:0] axi_slv_arburst,
   // read-data channel
   output logic                    axi_slv_rvalid,
   input  logic                    axi_slv_rready,
   output logic [`AXI_ID_W-1:0]    axi_slv_rid,
   output logic [`AXI_DATA_W-1:0]  axi_slv_rdata,
   output logic [`AXI_RESP_W-1:0]  axi_slv_rresp,
   output logic                    axi_slv_rlast,
   // status
   output logic                    busy
);

   localparam int unsigned ID_W    = `AXI_ID_W;
   localparam int unsigned ADDR_W  = `AXI_ADDR_W;
   localparam int unsigned LEN_W   = `AXI_LEN_W;
   localparam int unsigned SIZE_W  = `AXI_SIZE_W;
   localparam int unsigned BURST_W = `AXI_BURST_W;
   localparam int unsigned DATA_W  = `AXI_DATA_W;
   localparam int unsigned RESP_W  = `AXI_RESP_W;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned BUS_BYTES = DATA_W / 8;

   localparam logic [RESP_W-1:0]  RESP_OKAY   = RESP_W'(0);
   localparam logic [RESP_W-1:0]  RESP_SLVERR = RESP_W'(2);
   localparam logic [BURST_W-1:0] BURST_FIXED = BURST_W'(0);
   localparam logic [BURST_W-1:0] BURST_INCR  = BURST_W'(1);
   localparam logic [BURST_W-1:0] BURST_WRAP  = BURST_W'(2);
   localparam logic [BURST_W-1:0] BURST_RSVD  = BURST_W'(3);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_arready;
   logic                r_rvalid;
   logic                r_rlast;
   logic                r_busy;
   logic [ID_W-1:0]     r_rid;
   logic [DATA_W-1:0]   r_rdata;
   logic [RESP_W-1:0]   r_rresp;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_beat;
   logic [SIZE_W-1:0]   r_size;
   logic [BURST_W-1:0]  r_burst;
   logic                r_err;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_ar_hs;
   logic                w_r_hs;
   logic                w_req_err;
   logic [ADDR_W-1:0]   w_next_addr;
   logic [LEN_W-1:0]    w_beat_inc;

   // Bytes per beat for a given AxSIZE
   function automatic logic [ADDR_W-1:0] beat_bytes(input logic [SIZE_W-1:0] size);
      return ADDR_W'(1) << size;
   endfunction

   // Whole-burst error: beat wider than the bus, reserved burst, or illegal WRAP length
   function automatic logic request_err(input logic [LEN_W-1:0]   len,
                                        input logic [SIZE_W-1:0]  size,
                                        input logic [BURST_W-1:0] burst);
      logic bad_size;
      logic bad_wrap;
      bad_size = beat_bytes(size) > ADDR_W'(BUS_BYTES);
      bad_wrap = (burst == BURST_WRAP) &&
                 !((len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                   (len == LEN_W'(7)) || (len == LEN_W'(15)));
      return bad_size || bad_wrap || (burst == BURST_RSVD);
   endfunction

   // Address of the beat following addr
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0]  addr,
                                                   input logic [SIZE_W-1:0]  size,
                                                   input logic [LEN_W-1:0]   len,
                                                   input logic [BURST_W-1:0] burst);
      logic [ADDR_W-1:0] bytes;
      logic [ADDR_W-1:0] boundary;
      bytes    = beat_bytes(size);
      boundary = (ADDR_W'(len) + ADDR_W'(1)) * bytes;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = (addr & ~(bytes - ADDR_W'(1))) + bytes;
         BURST_WRAP:  next_addr = (addr & ~(boundary - ADDR_W'(1))) |
                                  ((addr + bytes) & (boundary - ADDR_W'(1)));
         default:     next_addr = addr;
      endcase
   endfunction

   // True when addr falls inside the decoded window
   function automatic logic in_window(input logic [ADDR_W-1:0] addr);
      return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < ADDR_W'(MEM_BYTES));
   endfunction

   // A beat is good only if the burst is legal and its address decodes
   function automatic logic beat_ok(input logic [ADDR_W-1:0] addr, input logic err);
      return !err && in_window(addr);
   endfunction

   function automatic logic [DATA_W-1:0] beat_rdata(input logic [ADDR_W-1:0] addr,
                                                    input logic err);
      return beat_ok(addr, err) ? DATA_W'(addr) : '0;
   endfunction

   function automatic logic [RESP_W-1:0] beat_rresp(input logic [ADDR_W-1:0] addr,
                                                    input logic err);
      return beat_ok(addr, err) ? RESP_OKAY : RESP_SLVERR;
   endfunction

   // Handshakes, request classification and next-beat address
   always_comb begin
      w_ar_hs     = axi_slv_arvalid && r_arready;
      w_r_hs      = r_rvalid && axi_slv_rready;
      w_req_err   = request_err(axi_slv_arlen, axi_slv_arsize, axi_slv_arburst);
      w_next_addr = next_addr(r_addr, r_size, r_len, r_burst);
      w_beat_inc  = r_beat + LEN_W'(1);
   end

   // Burst sequencer: accept one request, wait RD_LAT cycles, stream arlen+1 beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_busy    <= 1'b0;
         r_rid     <= '0;
         r_rdata   <= '0;
         r_rresp   <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_arready <= 1'b1;
               if (w_ar_hs) begin
                  r_arready <= 1'b0;
                  r_busy    <= 1'b1;
                  r_rid     <= axi_slv_arid;
                  r_addr    <= axi_slv_araddr;
                  r_len     <= axi_slv_arlen;
                  r_size    <= axi_slv_arsize;
                  r_burst   <= axi_slv_arburst;
                  r_err     <= w_req_err;
                  r_beat    <= '0;
                  if (RD_LAT == 0) begin
                     r_state  <= S_DATA;
                     r_rvalid <= 1'b1;
                     r_rdata  <= beat_rdata(axi_slv_araddr, w_req_err);
                     r_rresp  <= beat_rresp(axi_slv_araddr, w_req_err);
                     r_rlast  <= (axi_slv_arlen == '0);
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= CNT_W'(RD_LAT);
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_cnt    <= '0;
                  r_state  <= S_DATA;
                  r_rvalid <= 1'b1;
                  r_rdata  <= beat_rdata(r_addr, r_err);
                  r_rresp  <= beat_rresp(r_addr, r_err);
                  r_rlast  <= (r_len == '0);
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_DATA: begin
               if (w_r_hs) begin
                  if (r_rlast) begin
                     r_state   <= S_IDLE;
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_busy    <= 1'b0;
                     r_arready <= 1'b1;
                  end else begin
                     r_beat  <= w_beat_inc;
                     r_addr  <= w_next_addr;
                     r_rdata <= beat_rdata(w_next_addr, r_err);
                     r_rresp <= beat_rresp(w_next_addr, r_err);
                     r_rlast <= (w_beat_inc == r_len);
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_arready <= 1'b0;
               r_rvalid  <= 1'b0;
               r_rlast   <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign axi_slv_arready = r_arready;
   assign axi_slv_rvalid  = r_rvalid;
   assign axi_slv_rid     = r_rid;
   assign axi_slv_rdata   = r_rdata;
   assign axi_slv_rresp   = r_rresp;
   assign axi_slv_rlast   = r_rlast;
   assign busy            = r_busy;

endmodule

// File: tb/tb_easy_axi_rd_slv.sv
// tb_easy_axi_rd_slv: randomized bench for easy_axi_rd_slv against a behavioural burst model.
// Two instances: u_dut0 (base 0, 4 KiB, RD_LAT=1) and u_dut1 (base 0x1000, 256 B, RD_LAT=0).

module tb_easy_axi_rd_slv;

   localparam int unsigned ID_W    = 4;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned SIZE_W  = 3;
   localparam int unsigned BURST_W = 2;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned RESP_W  = 2;
   localparam int unsigned MAX_CYC = 400;

   localparam logic [ADDR_W-1:0] BASE0 = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] BASE1 = 32'h0000_1000;
   localparam int unsigned       MEM0  = 4096;
   localparam int unsigned       MEM1  = 256;
   localparam int unsigned       LAT0  = 1;
   localparam int unsigned       LAT1  = 0;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [1:0]           arvalid, arready, rvalid, rready, rlast, busy;
   logic [ID_W-1:0]      arid    [2];
   logic [ADDR_W-1:0]    araddr  [2];
   logic [LEN_W-1:0]     arlen   [2];
   logic [SIZE_W-1:0]    arsize  [2];
   logic [BURST_W-1:0]   arburst [2];
   logic [ID_W-1:0]      rid     [2];
   logic [DATA_W-1:0]    rdata   [2];
   logic [RESP_W-1:0]    rresp   [2];

   int vectors = 0;
   int miscompares = 0;

   logic [DATA_W-1:0] obs_data[$];
   logic [RESP_W-1:0] obs_resp[$];
   int                obs_last_idx;

   always #5 clk = ~clk;

   easy_axi_rd_slv #(.BASE_ADDR(BASE0), .MEM_BYTES(MEM0), .RD_LAT(LAT0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .axi_slv_arvalid(arvalid[0]), .axi_slv_arready(arready[0]), .axi_slv_arid(arid[0]),
      .axi_slv_araddr(araddr[0]), .axi_slv_arlen(arlen[0]), .axi_slv_arsize(arsize[0]),
      .axi_slv_arburst(arburst[0]),
      .axi_slv_rvalid(rvalid[0]), .axi_slv_rready(rready[0]), .axi_slv_rid(rid[0]),
      .axi_slv_rdata(rdata[0]), .axi_slv_rresp(rresp[0]), .axi_slv_rlast(rlast[0]),
      .busy(busy[0])
   );

   easy_axi_rd_slv #(.BASE_ADDR(BASE1), .MEM_BYTES(MEM1), .RD_LAT(LAT1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .axi_slv_arvalid(arvalid[1]), .axi_slv_arready(arready[1]), .axi_slv_arid(arid[1]),
      .axi_slv_araddr(araddr[1]), .axi_slv_arlen(arlen[1]), .axi_slv_arsize(arsize[1]),
      .axi_slv_arburst(arburst[1]),
      .axi_slv_rvalid(rvalid[1]), .axi_slv_rready(rready[1]), .axi_slv_rid(rid[1]),
      .axi_slv_rdata(rdata[1]), .axi_slv_rresp(rresp[1]), .axi_slv_rlast(rlast[1]),
      .busy(busy[1])
   );

   // ---------------- reference model ----------------
   function automatic bit m_err(input int len, input int size, input int burst);
      bit bad_wrap;
      bad_wrap = (burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15);
      return ((1 << size) > DATA_W / 8) || (burst == 3) || bad_wrap;
   endfunction

   function automatic logic [ADDR_W-1:0] m_next(input logic [ADDR_W-1:0] addr, input int len,
                                                input int size, input int burst);
      longint unsigned a, bytes, bnd;
      a     = longint'(addr);
      bytes = longint'(1) << size;
      bnd   = longint'(len + 1) * bytes;
      if (burst == 1) return ADDR_W'((a / bytes) * bytes + bytes);
      if (burst == 2) return ADDR_W'((a / bnd) * bnd + ((a + bytes) % bnd));
      return addr;
   endfunction

   function automatic bit m_in_win(input int sel, input logic [ADDR_W-1:0] addr);
      longint unsigned a, b, m;
      a = longint'(addr);
      b = (sel != 0) ? longint'(BASE1) : longint'(BASE0);
      m = (sel != 0) ? longint'(MEM1) : longint'(MEM0);
      return (a >= b) && (a < b + m);
   endfunction

   // Drive one burst on instance sel and check every observed beat against the model
   task automatic run_burst(input string name, input int sel, input int id,
                            input logic [ADDR_W-1:0] addr, input int len, input int size,
                            input int burst, input bit rnd_rdy, input logic [15:0] pat,
                            input bit hold_ar);
      logic [ADDR_W-1:0] exp_addr[$];
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] e_data;
      logic [RESP_W-1:0] e_resp;
      bit                err, ok, rr;
      int                lat, cyc, k, idx, low;
      lat = (sel != 0) ? int'(LAT1) : int'(LAT0);
      err = m_err(len, size, burst);
      a = addr;
      for (int i = 0; i <= len; i++) begin
         exp_addr.push_back(a);
         a = m_next(a, len, size, burst);
      end
      obs_data.delete();
      obs_resp.delete();
      obs_last_idx = -1;

      @(negedge clk);
      cyc = 0;
      while (arready[sel] !== 1'b1 && cyc < int'(MAX_CYC)) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= int'(MAX_CYC)) begin
         vectors++; miscompares++;
         $display("FAIL %s arready_timeout got 0 exp 1", name);
         return;
      end
      arvalid[sel] = 1'b1;
      arid[sel]    = ID_W'(id);
      araddr[sel]  = addr;
      arlen[sel]   = LEN_W'(len);
      arsize[sel]  = SIZE_W'(size);
      arburst[sel] = BURST_W'(burst);
      rready[sel]  = rnd_rdy ? 1'($urandom) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (arready[sel] !== 1'b0 || busy[sel] !== 1'b1) begin
         miscompares++;
         $display("FAIL %s post_hs arready/busy got %b/%b exp 0/1", name, arready[sel], busy[sel]);
      end
      arvalid[sel] = hold_ar;
      arid[sel]    = ID_W'($urandom);
      araddr[sel]  = $urandom;
      arlen[sel]   = LEN_W'($urandom);
      arsize[sel]  = SIZE_W'($urandom);
      arburst[sel] = BURST_W'($urandom);

      k = 0; idx = 0; low = 0; cyc = 0;
      while (k <= len && cyc < int'(MAX_CYC)) begin
         if (rvalid[sel] === 1'b1) begin
            if (k == 0 && idx == 0) begin
               vectors++;
               if (low != lat) begin
                  miscompares++;
                  $display("FAIL %s first_rvalid_latency got %0d exp %0d", name, low, lat);
               end
            end
            ok     = !err && m_in_win(sel, exp_addr[k]);
            e_data = ok ? DATA_W'(exp_addr[k]) : '0;
            e_resp = ok ? RESP_W'(0) : RESP_W'(2);
            vectors++;
            if (rdata[sel] !== e_data || rresp[sel] !== e_resp || rid[sel] !== ID_W'(id) ||
                rlast[sel] !== (k == len) || arready[sel] !== 1'b0 || busy[sel] !== 1'b1) begin
               miscompares++;
               $display("FAIL %s beat%0d got data=%h resp=%0d id=%0d last=%b ardy=%b busy=%b exp data=%h resp=%0d id=%0d last=%b ardy=0 busy=1",
                        name, k, rdata[sel], rresp[sel], rid[sel], rlast[sel], arready[sel],
                        busy[sel], e_data, e_resp, id, (k == len));
            end
            if (idx == 0 || obs_data.size() == k) begin
               obs_data.push_back(rdata[sel]);
               obs_resp.push_back(rresp[sel]);
            end
            if (rlast[sel] === 1'b1 && obs_last_idx < 0) obs_last_idx = k;
            rr = rnd_rdy ? 1'($urandom_range(0, 1)) : ((idx < 16) ? pat[idx] : 1'b1);
            idx++;
            rready[sel] = rr;
            if (rr) k++;
         end else begin
            if (k != 0 || idx != 0) begin
               vectors++; miscompares++;
               $display("FAIL %s rvalid_dropped beat%0d got 0 exp 1", name, k);
            end
            low++;
            rready[sel] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      arvalid[sel] = 1'b0;
      rready[sel]  = 1'b0;
      vectors++;
      if (cyc >= int'(MAX_CYC)) begin
         miscompares++;
         $display("FAIL %s beat_timeout got %0d beats exp %0d", name, k, len + 1);
      end else if (rvalid[sel] !== 1'b0 || arready[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
         miscompares++;
         $display("FAIL %s end_state rvalid/arready/busy got %b/%b/%b exp 0/1/0",
                  name, rvalid[sel], arready[sel], busy[sel]);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      arvalid = '0; rready = '0;
      for (int s = 0; s < 2; s++) begin
         arid[s] = '0; araddr[s] = '0; arlen[s] = '0; arsize[s] = '0; arburst[s] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         vectors++;
         if (arready[s] !== 1'b0 || rvalid[s] !== 1'b0 || rlast[s] !== 1'b0 || busy[s] !== 1'b0 ||
             rid[s] !== '0 || rdata[s] !== '0 || rresp[s] !== '0) begin
            miscompares++;
            $display("FAIL reset_values dut%0d got ardy=%b rv=%b rl=%b busy=%b rid=%h rdata=%h rresp=%h exp all 0",
                     s, arready[s], rvalid[s], rlast[s], busy[s], rid[s], rdata[s], rresp[s]);
         end
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (arready !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_release_pre_edge arready got %b exp 00", arready);
      end
      @(negedge clk);
      vectors++;
      if (arready !== 2'b11) begin
         miscompares++;
         $display("FAIL reset_release_first_edge arready got %b exp 11", arready);
      end
   endtask

   task automatic test_incr();
      logic [DATA_W-1:0] exp_d[4];
      exp_d = '{32'h100, 32'h104, 32'h108, 32'h10C};
      run_burst("incr", 0, 3, 32'h100, 3, 2, 1, 1'b0, 16'hFFFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (obs_data.size() != 4 || obs_data[i] !== exp_d[i] || obs_resp[i] !== 2'd0) begin
            miscompares++;
            $display("FAIL incr_const beat%0d got %h exp %h", i,
                     (obs_data.size() > i) ? obs_data[i] : 32'hX, exp_d[i]);
         end
      end
      vectors++;
      if (obs_last_idx != 3) begin
         miscompares++;
         $display("FAIL incr_rlast_pos got %0d exp 3", obs_last_idx);
      end
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] exp_d[4];
      exp_d = '{32'h108, 32'h10C, 32'h100, 32'h104};
      run_burst("wrap", 0, 5, 32'h108, 3, 2, 2, 1'b0, 16'hFFFF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (obs_data.size() != 4 || obs_data[i] !== exp_d[i]) begin
            miscompares++;
            $display("FAIL wrap_const beat%0d got %h exp %h", i,
                     (obs_data.size() > i) ? obs_data[i] : 32'hX, exp_d[i]);
         end
      end
      vectors++;
      if (obs_last_idx != 3) begin
         miscompares++;
         $display("FAIL wrap_rlast_pos got %0d exp 3", obs_last_idx);
      end
      run_burst("wrap8_b", 0, 6, 32'h23C, 7, 2, 2, 1'b1, 16'h0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_burst("fixed_bp", 0, 9, 32'h20, 2, 2, 0, 1'b0, 16'hFFF9, 1'b1);
      vectors++;
      if (obs_data.size() != 3 || obs_data[0] !== 32'h20 || obs_data[2] !== 32'h20) begin
         miscompares++;
         $display("FAIL fixed_bp_beats got %0d beats exp 3 of 00000020", obs_data.size());
      end
      run_burst("incr_rnd_bp", 0, 2, 32'h3F0, 5, 1, 1, 1'b1, 16'h0, 1'b1);
   endtask

   task automatic test_errors();
      run_burst("err_incr_edge", 0, 1, BASE0 + 32'(MEM0) - 32'd4, 1, 2, 1, 1'b0, 16'hFFFF, 1'b0);
      vectors++;
      if (obs_resp.size() != 2 || obs_resp[0] !== 2'd0 || obs_resp[1] !== 2'd2 || obs_data[1] !== '0) begin
         miscompares++;
         $display("FAIL err_incr_edge_resp got %0d beats exp OKAY then SLVERR", obs_resp.size());
      end
      run_burst("err_wrap_len2", 0, 2, 32'h40, 2, 2, 2, 1'b0, 16'hFFFF, 1'b0);
      vectors++;
      if (obs_resp.size() != 3 || obs_resp[0] !== 2'd2 || obs_resp[2] !== 2'd2 || obs_data[1] !== '0) begin
         miscompares++;
         $display("FAIL err_wrap_len2_resp got %0d beats exp 3 SLVERR", obs_resp.size());
      end
      run_burst("err_size8", 0, 3, 32'h80, 1, 3, 1, 1'b0, 16'hFFFF, 1'b0);
      run_burst("err_burst3", 0, 4, 32'h80, 2, 2, 3, 1'b0, 16'hFFFF, 1'b0);
      run_burst("incr_addr_wrap", 0, 7, 32'hFFFF_FFFC, 2, 2, 1, 1'b0, 16'hFFFF, 1'b0);
      run_burst("lat0_below_base", 1, 8, BASE1 - 32'd4, 2, 2, 1, 1'b0, 16'hFFFF, 1'b0);
   endtask

   task automatic test_lat0();
      run_burst("lat0_incr", 1, 10, BASE1 + 32'h10, 3, 2, 1, 1'b0, 16'hFFFF, 1'b0);
      run_burst("lat0_single", 1, 11, BASE1 + 32'hFC, 0, 2, 1, 1'b0, 16'hFFFF, 1'b1);
      run_burst("lat0_top_edge", 1, 12, BASE1 + 32'hF8, 3, 2, 1, 1'b1, 16'h0, 1'b0);
   endtask

   task automatic test_reset_mid_burst();
      int cyc;
      @(negedge clk);
      arvalid[0] = 1'b1; arid[0] = 4'd6; araddr[0] = 32'h200; arlen[0] = 8'd3;
      arsize[0] = 3'd2; arburst[0] = 2'd1; rready[0] = 1'b1;
      @(negedge clk);
      arvalid[0] = 1'b0;
      cyc = 0;
      while (!(rvalid[0] === 1'b1 && rdata[0] === 32'h204) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc >= 50) begin
         miscompares++;
         $display("FAIL rst_mid_reach_beat2 got timeout exp beat 00000204");
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (rvalid !== 2'b00 || busy !== 2'b00 || arready !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_mid_async got rvalid=%b busy=%b arready=%b exp 00/00/00", rvalid, busy, arready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rready[0] = 1'b0;
      vectors++;
      if (arready !== 2'b11) begin
         miscompares++;
         $display("FAIL rst_mid_arready got %b exp 11", arready);
      end
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (rvalid !== 2'b00 || busy !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_residual cycle%0d got rvalid=%b busy=%b exp 00/00", i, rvalid, busy);
         end
         rready[0] = 1'($urandom);
         @(negedge clk);
      end
      rready[0] = 1'b0;
   endtask

   task automatic test_random();
      int sel, len, size, burst, pick;
      logic [ADDR_W-1:0] base, addr;
      int unsigned mem;
      for (int n = 0; n < 40; n++) begin
         sel  = int'($urandom_range(0, 1));
         base = (sel != 0) ? BASE1 : BASE0;
         mem  = (sel != 0) ? MEM1 : MEM0;
         len  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 7));
         size = ($urandom_range(0, 5) == 0) ? 3 : int'($urandom_range(0, 2));
         pick = int'($urandom_range(0, 9));
         burst = (pick < 4) ? 1 : (pick < 7) ? 2 : (pick < 9) ? 0 : 3;
         pick = int'($urandom_range(0, 3));
         case (pick)
            0: addr = base + 32'($urandom_range(0, mem - 1));
            1: addr = base + 32'(mem) - 32'($urandom_range(1, 16));
            2: addr = base - 32'($urandom_range(1, 16));
            default: addr = $urandom;
         endcase
         run_burst("random", sel, int'($urandom_range(0, 15)), addr, len, size, burst,
                   1'($urandom), 16'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) begin
         run_burst("b2b_d0", 0, n, 32'h300 + 32'(n * 16), 1, 2, 1, 1'b0, 16'hFFFF, 1'b1);
         run_burst("b2b_d1", 1, n + 4, BASE1 + 32'(n * 8), 1, 2, 2, 1'b0, 16'hFFFF, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_backpressure();
      test_errors();
      test_lat0();
      test_back_to_back();
      test_random();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
